// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 3-sample majority voting, parity/framing flags
// and a show-ahead receive FIFO with sticky overrun.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_rx,
    input  logic                          rxd,
    input  logic                          rd,
    input  logic                          clr_ovr,
    output logic [DATA_BITS-1:0]          d_out,
    output logic [1:0]                    err_out,
    output logic                          rs,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          IRQ
);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int TW   = $clog2(OVERSAMPLE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = DATA_BITS + 2;

    localparam logic [TW-1:0] T_S0   = TW'(HALF - 1);
    localparam logic [TW-1:0] T_S1   = TW'(HALF);
    localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    B_LAST = 4'(DATA_BITS);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic x;
        x = (^data) ^ pbit;
        return (PARITY == 1) ? ~x : x;
    endfunction

    logic [1:0]           sync_r;
    logic                 rx_s;
    state_t               state_r;
    logic [TW-1:0]        tick_r;
    logic [3:0]           bit_cnt_r;
    logic [1:0]           samp_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_err_r;

    logic [EW-1:0]        mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic                 overrun_r;

    logic                 dec_s;
    logic                 wrap_s;
    logic                 maj_s;
    logic                 push_s;
    logic [EW-1:0]        push_data_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 wr_s;
    logic                 ovf_s;
    logic [EW-1:0]        head_s;

    assign rx_s        = sync_r[1];
    assign dec_s       = en_rx && (tick_r == T_DEC);
    assign wrap_s      = (tick_r == T_LAST);
    assign maj_s       = majority3(samp_r[0], samp_r[1], rx_s);
    assign push_s      = dec_s && (state_r == STOP);
    assign push_data_s = {par_err_r, ~maj_s, shift_r};
    assign pop_s       = rd && (count_r != {CW{1'b0}});
    assign full_s      = (count_r == C_FULL);
    assign wr_s        = push_s && (!full_s || pop_s);
    assign ovf_s       = push_s && full_s && !pop_s;
    assign head_s      = mem_r[rd_ptr_r];

    // Two-flop synchroniser for the asynchronous serial input, idling high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rxd};
        end
    end

    // Receive FSM: tick counting, majority sampling, shifting and flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            tick_r    <= '0;
            bit_cnt_r <= 4'd0;
            samp_r    <= 2'b11;
            shift_r   <= '0;
            par_err_r <= 1'b0;
        end else if (en_rx) begin
            if (tick_r == T_S0) samp_r[0] <= rx_s;
            if (tick_r == T_S1) samp_r[1] <= rx_s;
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_r   <= START;
                        tick_r    <= TW'(1);
                        bit_cnt_r <= 4'd0;
                        par_err_r <= 1'b0;
                    end
                end
                BRK: begin
                    tick_r <= '0;
                    if (rx_s) state_r <= IDLE;
                end
                default: begin
                    tick_r <= wrap_s ? '0 : tick_r + TW'(1);
                    case (state_r)
                        START: begin
                            if (dec_s && maj_s) begin
                                state_r <= IDLE;
                                tick_r  <= '0;
                            end else if (wrap_s) begin
                                state_r <= DATA;
                            end
                        end
                        DATA: begin
                            if (dec_s) begin
                                shift_r   <= {maj_s, shift_r[DATA_BITS-1:1]};
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                            if (wrap_s && (bit_cnt_r == B_LAST)) begin
                                state_r <= (PARITY != 0) ? PAR : STOP;
                            end
                        end
                        PAR: begin
                            if (dec_s) par_err_r <= parity_error(shift_r, maj_s);
                            if (wrap_s) state_r <= STOP;
                        end
                        STOP: begin
                            // Leave on the decision tick so a following start bit is caught early.
                            if (dec_s) begin
                                state_r <= maj_s ? IDLE : BRK;
                                tick_r  <= '0;
                            end
                        end
                        default: begin
                            state_r <= IDLE;
                            tick_r  <= '0;
                        end
                    endcase
                end
            endcase
        end
    end

    // Receive FIFO storage, pointers, occupancy and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (ovf_s) begin
                overrun_r <= 1'b1;
            end else if (clr_ovr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Show-ahead head presentation, forced to zero while empty.
    always_comb begin
        if (count_r != {CW{1'b0}}) begin
            d_out   = head_s[DATA_BITS-1:0];
            err_out = head_s[EW-1:EW-2];
        end else begin
            d_out   = '0;
            err_out = 2'b00;
        end
    end

    assign rs      = (count_r != {CW{1'b0}});
    assign count   = count_r;
    assign overrun = overrun_r;
    assign IRQ     = rs | overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: a default instance and a
// 7-bit even-parity instance, driven with hand-built frames at en_rx = every clk.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst, en_rx, rxd, rd, clr_ovr;
    logic       rxd_p, rd_p;

    logic [7:0] d_out;
    logic [1:0] err_out;
    logic       rs, overrun, irq;
    logic [2:0] count;

    logic [6:0] d_out_p;
    logic [1:0] err_p;
    logic       rs_p, ovr_p, irq_p;
    logic [2:0] count_p;

    int n_chk  = 0;
    int n_pass = 0;

    uart_rx_fifo u_dut (
        .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd), .rd(rd), .clr_ovr(clr_ovr),
        .d_out(d_out), .err_out(err_out), .rs(rs), .count(count),
        .overrun(overrun), .IRQ(irq)
    );

    uart_rx_fifo #(.DATA_BITS(7), .PARITY(2)) u_par (
        .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd_p), .rd(rd_p), .clr_ovr(clr_ovr),
        .d_out(d_out_p), .err_out(err_p), .rs(rs_p), .count(count_p),
        .overrun(ovr_p), .IRQ(irq_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start + 8 data (LSB first) + stop, bit 0 first on the wire.
    function automatic logic [15:0] frame8(input logic [7:0] data, input logic stop);
        return {6'd0, stop, data, 1'b0};
    endfunction

    function automatic logic [15:0] frame7p(input logic [6:0] data, input logic pbit);
        return {6'd0, 1'b1, pbit, data, 1'b0};
    endfunction

    // Loop iteration i of a bit lands on receiver tick i; gmask inverts chosen ticks of bit gbit.
    task automatic send(input logic sel, input logic [15:0] bits, input int nbits,
                        input int gbit, input logic [15:0] gmask, input logic rd_end,
                        input logic chk_lat);
        logic v;
        for (int b = 0; b < nbits; b++) begin
            for (int i = 0; i < 8; i++) begin
                v = bits[b] ^ ((b == gbit) && gmask[i]);
                if (sel) rxd_p = v;
                else     rxd   = v;
                if (rd_end && (b == nbits - 1) && (i == 7)) rd = 1'b1;
                if (chk_lat && (b == nbits - 1) && (i == 7)) check("t1_rs_before_push", rs, 0);
                @(posedge clk);
                #1;
                rd = 1'b0;
            end
        end
    endtask

    task automatic pop(input logic sel);
        if (sel) rd_p = 1'b1;
        else     rd   = 1'b1;
        @(posedge clk);
        #1;
        rd   = 1'b0;
        rd_p = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_rx = 1'b1; rxd = 1'b1; rxd_p = 1'b1;
        rd = 1'b0; rd_p = 1'b0; clr_ovr = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_rs", rs, 0);
        check("rst_count", count, 0);
        check("rst_dout", d_out, 0);
        check("rst_err", err_out, 0);
        check("rst_ovr", overrun, 0);
        check("rst_irq", irq, 0);
        pop(1'b0);
        check("rd_empty_count", count, 0);

        // Basic frame
        send(1'b0, frame8(8'hA5, 1'b1), 10, -1, 16'h0, 1'b0, 1'b1);
        check("t1_rs", rs, 1);
        check("t1_count", count, 1);
        check("t1_dout", d_out, 8'hA5);
        check("t1_err", err_out, 2'b00);
        check("t1_irq", irq, 1);
        pop(1'b0);
        check("t1_pop_rs", rs, 0);
        check("t1_pop_count", count, 0);
        check("t1_pop_dout", d_out, 0);
        check("t1_pop_irq", irq, 0);

        // Start glitch, then a clean frame to show recovery
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(20);
        check("t2_glitch_rs", rs, 0);
        check("t2_glitch_count", count, 0);
        send(1'b0, frame8(8'h3C, 1'b1), 10, -1, 16'h0, 1'b0, 1'b0);
        check("t2_after_dout", d_out, 8'h3C);
        pop(1'b0);

        // Majority filtering on data bit 3
        send(1'b0, frame8(8'h00, 1'b1), 10, 4, 16'h0010, 1'b0, 1'b0);
        check("t3_one_dout", d_out, 8'h00);
        check("t3_one_err", err_out, 2'b00);
        pop(1'b0);
        send(1'b0, frame8(8'h00, 1'b1), 10, 4, 16'h0030, 1'b0, 1'b0);
        check("t3_two_dout", d_out, 8'h08);
        pop(1'b0);

        // Even parity, 7 data bits, back-to-back frames
        send(1'b1, frame7p(7'h07, 1'b1), 10, -1, 16'h0, 1'b0, 1'b0);
        send(1'b1, frame7p(7'h07, 1'b0), 10, -1, 16'h0, 1'b0, 1'b0);
        check("t4_count", count_p, 2);
        check("t4_good_dout", d_out_p, 7'h07);
        check("t4_good_err", err_p, 2'b00);
        pop(1'b1);
        check("t4_bad_dout", d_out_p, 7'h07);
        check("t4_bad_err", err_p, 2'b10);
        pop(1'b1);
        check("t4_empty", count_p, 0);

        // Framing error followed by a held-low break
        send(1'b0, frame8(8'h55, 1'b0), 9, -1, 16'h0, 1'b0, 1'b0);
        rxd = 1'b0;
        tick(30);
        check("t5_count", count, 1);
        check("t5_dout", d_out, 8'h55);
        check("t5_err", err_out, 2'b01);
        rxd = 1'b1;
        tick(4);
        check("t5_one_push", count, 1);
        pop(1'b0);
        send(1'b0, frame8(8'hC3, 1'b1), 10, -1, 16'h0, 1'b0, 1'b0);
        check("t5_next_dout", d_out, 8'hC3);
        check("t5_next_err", err_out, 2'b00);
        pop(1'b0);

        // Overrun
        for (int v = 1; v <= 5; v++) begin
            send(1'b0, frame8(8'(v), 1'b1), 10, -1, 16'h0, 1'b0, 1'b0);
        end
        check("t6_full_count", count, 4);
        check("t6_ovr", overrun, 1);
        check("t6_head", d_out, 8'h01);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        check("t6_clr_ovr", overrun, 0);
        check("t6_clr_irq", irq, 1);
        send(1'b0, frame8(8'h06, 1'b1), 10, -1, 16'h0, 1'b1, 1'b0);
        check("t6_rdpush_count", count, 4);
        check("t6_rdpush_ovr", overrun, 0);
        check("t6_rdpush_head", d_out, 8'h02);
        send(1'b0, frame8(8'h07, 1'b1), 10, -1, 16'h0, 1'b0, 1'b0);
        check("t6_ovr_again", overrun, 1);
        check("t6_head_kept", d_out, 8'h02);

        // Reset in the middle of a frame
        send(1'b0, frame8(8'h5A, 1'b1), 4, -1, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("t6_rst_rs", rs, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_dout", d_out, 0);
        check("t6_rst_err", err_out, 0);
        check("t6_rst_ovr", overrun, 0);
        check("t6_rst_irq", irq, 0);
        send(1'b0, frame8(8'h81, 1'b1), 10, -1, 16'h0, 1'b0, 1'b0);
        check("t6_post_rst_count", count, 1);
        check("t6_post_rst_dout", d_out, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised oversampling UART receiver, successor to the fixed 8-bit MiniUart receive unit. It adds:
- configurable data width, oversampling ratio and parity;
- 3-sample majority voting;
- per-frame parity/framing error flags;
- a show-ahead receive FIFO with sticky overrun.

It sits between the RxD pin and the CPU bus bridge, which pops bytes and services IRQ.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
- OVERSAMPLE, 8, en_rx ticks per bit, legal 8 or 16; HALF = OVERSAMPLE/2
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- FIFO_DEPTH, 4, receive entries, power of 2, at least 2
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- en_rx  in  1  oversample tick, one clk wide, OVERSAMPLE × baud
- rxd  in  1  serial input, idle high, asynchronous to clk
- rd  in  1  pop FIFO head, one-cycle pulse; ignored when empty
- clr_ovr  in  1  clears overrun
- d_out  out  DATA_BITS  FIFO head data; 0 when empty
- err_out  out  2  head flags {parity_err, framing_err}; 0 when empty
- rs  out  1  FIFO non-empty
- count  out  clog2(FIFO_DEPTH)+1  entries held
- overrun  out  1  sticky: a frame was dropped because the FIFO was full
- IRQ  out  1  rs | overrun, combinational from registers

## Operation
- **Synchroniser:** rxd passes through a 2-flop synchroniser (reset to 1). All decisions use the synchronised value (rx_s).
- **Tick counter:** tick_cnt counts en_rx ticks within a bit, 0..OVERSAMPLE-1. The FSM and tick_cnt advance only on en_rx cycles. When en_rx=0 they hold, and the FIFO remains fully operable.
- **Majority sampling:** at ticks HALF-1, HALF and HALF+1, rx_s is sampled. The bit value is the 2-of-3 majority, decided at tick HALF+1 (the decision tick).
- **FSM states:** IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: on an en_rx tick with rx_s=0, go to START. That tick is tick 0 (tick_cnt set to 1 for the next tick).
  - START: at the decision tick, majority 1 means glitch and the FSM returns to IDLE. Otherwise it goes to DATA at the bit boundary.
  - Bit boundary: the tick on which tick_cnt=OVERSAMPLE-1 wraps to 0.
  - DATA: shifts each decided bit into the MSB of the shift register (LSB first). After DATA_BITS bits it moves to PAR if PARITY≠0, else STOP.
  - PAR: parity_err = XOR(data, parity bit) ≠ (PARITY==1 ? 1 : 0). parity_err is always 0 when PARITY=0.
  - STOP: at the decision tick, framing_err = !majority and the frame is pushed. Then, still on the decision tick, go to IDLE if majority=1, else BRK. Leaving before the bit ends gives early resync for back-to-back frames.
  - BRK: stay until an en_rx tick with rx_s=1, then go to IDLE.
- **Frames:** erroneous frames are still stored, with their flags.
- **FIFO:** show-ahead; the head is visible on d_out/err_out with no read latency. A pop advances the head on the rd cycle.
- **FIFO boundary cases:**
  - Push when full and no rd: frame dropped, overrun←1, contents unchanged.
  - Push and rd in the same cycle when full: pop then push, no overrun, count unchanged.
  - Push and rd in the same cycle when empty: rd ignored, count becomes 1.
- **Overrun:** cleared only by clr_ovr or rst. A set and clr_ovr in the same cycle leave overrun=1.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH. count distinguishes full from empty.

## Timing
- **Reset values:** rs=0, count=0, d_out=0, err_out=0, overrun=0, IRQ=0. FSM=IDLE, synchroniser=1, tick_cnt=0.
- **Reset mid-frame:** the partial frame is discarded and the FIFO is flushed.
- **Synchroniser latency:** rx_s lags rxd by 2 clk.
- **Push latency:** the push is registered on the clk edge ending the STOP decision-tick cycle. rs, count and IRQ update that same edge, so they are visible the next cycle.
- **Frame length:** (1 + DATA_BITS + (PARITY≠0) + 1) × OVERSAMPLE ticks nominal. The receiver is ready for a new start bit HALF+2 ticks into the stop bit.
- **Pop timing:** count decrements on the edge ending the rd cycle. The new head appears in the following cycle.

## Test plan
1. **Basic frame:** defaults, en_rx every clk, frame 0xA5 with stop 1 -> rs=1, count=1, d_out=0xA5, err_out=00, IRQ=1 one cycle after the stop decision tick. rd pulse -> rs=0, count=0, d_out=0, IRQ=0.
2. **Start glitch:** rxd low for 2 ticks, then high -> FSM returns to IDLE at the START decision tick; no push, rs stays 0.
3. **Majority filtering:** frame 0x00 with rxd forced high only at tick HALF of data bit 3 -> d_out=0x00, err_out=00. The same frame forced high at ticks HALF and HALF+1 -> d_out=0x08.
4. **Parity and back-to-back frames:** PARITY=2, DATA_BITS=7, frame 0x07 with parity bit 1 -> err_out=00. Parity bit 0 -> err_out=10. Two back-to-back frames are both received, count=2.
5. **Framing error and break:** frame 0x55 with stop bit 0 and rxd held low 30 ticks -> d_out=0x55, err_out=01, exactly one push. Next start is accepted only after rxd returns high.
6. **Overrun:** FIFO_DEPTH=4, five frames 0x01..0x05, no rd -> count=4, overrun=1, head 0x01, 0x05 lost. rd coincident with a 6th push while full -> count stays 4, no further overrun event. clr_ovr -> overrun=0, IRQ=rs. rst mid-frame -> all outputs back to their reset values.
